// File: rtl/usb_pkg.sv
// Shared constants, types and helpers for the USB bitstream packet decoder.
package usb_pkg;

   localparam logic [7:0] SYNC        = 8'b0000_0001;

   localparam logic [1:0] TYPE_NONE   = 2'b00;
   localparam logic [1:0] TYPE_TOKEN  = 2'b01;
   localparam logic [1:0] TYPE_HSHAKE = 2'b10;
   localparam logic [1:0] TYPE_DATA   = 2'b11;

   localparam int PID_BITS       = 8;
   localparam int PAYLOAD_HSHAKE = 0;
   localparam int PAYLOAD_TOKEN  = 16;
   localparam int PAYLOAD_DATA   = 80;

   localparam int DATA_W   = 72;
   localparam int TOKEN_W  = 19;
   localparam int HSHAKE_W = 8;

   localparam int CNT_W = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PID,
      S_PAYLOAD,
      S_WAIT_EOP,
      S_DONE
   } state_t;

   // Counter value seen while the final expected bit of a packet arrives; the
   // counter runs from the first PID bit, so this is PID + payload - 1.
   function automatic logic [CNT_W-1:0] lastBitIdx(input logic [1:0] t);
      case (t)
         TYPE_TOKEN: lastBitIdx = CNT_W'(PID_BITS + PAYLOAD_TOKEN - 1);
         TYPE_DATA:  lastBitIdx = CNT_W'(PID_BITS + PAYLOAD_DATA - 1);
         default:    lastBitIdx = CNT_W'(PID_BITS + PAYLOAD_HSHAKE - 1);
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] fieldEnd(input logic [1:0] t);
      case (t)
         TYPE_TOKEN: fieldEnd = CNT_W'(TOKEN_W);
         TYPE_DATA:  fieldEnd = CNT_W'(DATA_W);
         default:    fieldEnd = CNT_W'(HSHAKE_W);
      endcase
   endfunction

endpackage

// File: rtl/counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module counter #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_en && (r_count != '1))
         r_count <= r_count + WIDTH'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/sipo_register.sv
// Serial-in parallel-out shift register, shifting left (new bit enters at LSB).
module sipo_register #(
   parameter int WIDTH = 72
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_q <= '0;
      else if (i_en)
         r_q <= {r_q[WIDTH-2:0], i_bit};
   end

   assign o_q = r_q;

endmodule

// File: rtl/bs_decoder.sv
// USB bitstream packet decoder: finds SYNC, checks the PID and captures
// token / handshake / data fields into held outputs until acknowledged.
module bs_decoder
   import usb_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_in,
   input  logic                s_valid,
   input  logic                eop,
   input  logic                crc_ok,
   input  logic                pkt_ack,
   output logic [1:0]          pkt_type,
   output logic [DATA_W-1:0]   data,
   output logic [TOKEN_W-1:0]  token,
   output logic [HSHAKE_W-1:0] hshake,
   output logic                pkt_rcvd,
   output logic                pkt_err,
   output logic                crc_en,
   output logic                crc_clr
);

   state_t             r_state, w_next;
   logic [7:0]         r_win;
   logic [7:0]         w_winNext;
   logic [1:0]         r_cat;
   logic [1:0]         w_type;
   logic [CNT_W-1:0]   w_count;
   logic [DATA_W-1:0]  w_sipo, w_sipoNext;
   logic [7:0]         w_pidByte;
   logic               w_pidOk, w_pidEnd, w_last;
   logic               w_syncHit, w_shift, w_cntEn, w_err, w_accept;

   // The SIPO collects PID then field bits, so the low bits of its next value
   // always hold the complete field for whichever packet type is accepted.
   assign w_winNext  = {r_win[6:0], s_in};
   assign w_sipoNext = w_shift ? {w_sipo[DATA_W-2:0], s_in} : w_sipo;
   assign w_pidByte  = w_sipoNext[7:0];
   assign w_pidOk    = (w_pidByte[7:4] == ~w_pidByte[3:0]) && (w_pidByte[1:0] != TYPE_NONE);
   assign w_pidEnd   = (r_state == S_PID) && s_valid && (w_count == CNT_W'(PID_BITS - 1));
   assign w_type     = (r_state == S_PID) ? w_pidByte[1:0] : r_cat;
   assign w_last     = (r_state == S_PAYLOAD) && s_valid && (w_count == lastBitIdx(r_cat));

   counter #(.WIDTH(CNT_W)) u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_syncHit),
      .i_en    (w_cntEn),
      .o_count (w_count)
   );

   sipo_register #(.WIDTH(DATA_W)) u_sipo (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_shift),
      .i_bit (s_in),
      .o_q   (w_sipo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_err    = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s_valid && (w_winNext == SYNC))
               w_next = S_PID;
         end
         S_PID: begin
            if (w_pidEnd) begin
               if (!w_pidOk)
                  w_err = 1'b1;
               else if (w_type == TYPE_HSHAKE) begin
                  if (eop)
                     w_accept = 1'b1;
                  else
                     w_next = S_WAIT_EOP;
               end
               else if (eop)
                  w_err = 1'b1;
               else
                  w_next = S_PAYLOAD;
            end
            else if (eop)
               w_err = 1'b1;
         end
         S_PAYLOAD: begin
            if (w_last) begin
               if (!eop)
                  w_next = S_WAIT_EOP;
               else if (crc_ok)
                  w_accept = 1'b1;
               else
                  w_err = 1'b1;
            end
            else if (eop)
               w_err = 1'b1;
         end
         S_WAIT_EOP: begin
            if (s_valid)
               w_err = 1'b1;
            else if (eop) begin
               if (crc_ok || (r_cat == TYPE_HSHAKE))
                  w_accept = 1'b1;
               else
                  w_err = 1'b1;
            end
         end
         S_DONE: begin
            if (pkt_ack)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_err)
         w_next = S_IDLE;
      else if (w_accept)
         w_next = S_DONE;
   end

   always_comb begin
      crc_en    = 1'b0;
      w_syncHit = 1'b0;
      w_shift   = 1'b0;
      w_cntEn   = 1'b0;
      case (r_state)
         S_IDLE:
            w_syncHit = s_valid && (w_winNext == SYNC);
         S_PID: begin
            w_shift = s_valid;
            w_cntEn = s_valid;
         end
         S_PAYLOAD: begin
            crc_en  = s_valid;
            w_cntEn = s_valid;
            w_shift = s_valid && (w_count < fieldEnd(r_cat));
         end
         default: ;
      endcase
   end

   // Registered outputs; only the field matching the accepted type is updated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win    <= '0;
         r_cat    <= TYPE_NONE;
         crc_clr  <= 1'b0;
         pkt_err  <= 1'b0;
         pkt_rcvd <= 1'b0;
         pkt_type <= TYPE_NONE;
         data     <= '0;
         token    <= '0;
         hshake   <= '0;
      end
      else begin
         crc_clr <= w_syncHit;
         pkt_err <= w_err;
         if ((r_state == S_IDLE) && s_valid)
            r_win <= w_winNext;
         if (w_pidEnd)
            r_cat <= w_pidByte[1:0];
         if (w_accept) begin
            pkt_rcvd <= 1'b1;
            pkt_type <= w_type;
            case (w_type)
               TYPE_TOKEN:  token  <= w_sipoNext[TOKEN_W-1:0];
               TYPE_HSHAKE: hshake <= w_sipoNext[HSHAKE_W-1:0];
               TYPE_DATA:   data   <= w_sipoNext;
               default: ;
            endcase
         end
         else if ((r_state == S_DONE) && pkt_ack) begin
            pkt_rcvd <= 1'b0;
            pkt_type <= TYPE_NONE;
         end
      end
   end

endmodule

// File: tb/tb_bs_decoder.sv
// Directed self-checking bench for bs_decoder: handshake, token and data
// packets, PID / CRC / length errors, DONE hold and mid-packet reset.
module tb_bs_decoder;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        s_in    = 1'b0;
   logic        s_valid = 1'b0;
   logic        eop     = 1'b0;
   logic        crc_ok  = 1'b0;
   logic        pkt_ack = 1'b0;
   logic [1:0]  pkt_type;
   logic [71:0] data;
   logic [18:0] token;
   logic [7:0]  hshake;
   logic        pkt_rcvd;
   logic        pkt_err;
   logic        crc_en;
   logic        crc_clr;

   int total = 0;
   int bad   = 0;

   bs_decoder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_in     (s_in),
      .s_valid  (s_valid),
      .eop      (eop),
      .crc_ok   (crc_ok),
      .pkt_ack  (pkt_ack),
      .pkt_type (pkt_type),
      .data     (data),
      .token    (token),
      .hshake   (hshake),
      .pkt_rcvd (pkt_rcvd),
      .pkt_err  (pkt_err),
      .crc_en   (crc_en),
      .crc_clr  (crc_clr)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are looked at 1 ns after the rising edge.
   task automatic applyStimulus(input logic b, input logic v, input logic e,
                                input logic ok, input logic ack);
      @(negedge clk);
      s_in    = b;
      s_valid = v;
      eop     = e;
      crc_ok  = ok;
      pkt_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Sends the n low bits of val, MSB first, optionally with an idle gap after each.
   task automatic sendBits(input logic [79:0] val, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(val[i], 1'b1, 1'b0, 1'b0, 1'b0);
         if (gaps)
            idleCycle();
      end
   endtask

   task automatic sendSync(input bit gaps);
      sendBits(80'h01, 8, gaps);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gaps);
      sendBits({72'h0, b}, 8, gaps);
   endtask

   task automatic checkOutput(input string tag, input logic [71:0] observed,
                              input logic [71:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the end of the sequence");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      $display("[TB] starting bs_decoder directed test");

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_pkt_type", 72'(pkt_type), 72'h0);
      checkOutput("rst_pkt_rcvd", 72'(pkt_rcvd), 72'h0);
      checkOutput("rst_pkt_err",  72'(pkt_err),  72'h0);
      checkOutput("rst_crc_en",   72'(crc_en),   72'h0);
      checkOutput("rst_crc_clr",  72'(crc_clr),  72'h0);
      checkOutput("rst_data",     data,          72'h0);
      checkOutput("rst_token",    72'(token),    72'h0);
      checkOutput("rst_hshake",   72'(hshake),   72'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle();

      $display("[TB] ACK handshake");
      sendSync(0);
      checkOutput("ack_crc_clr", 72'(crc_clr), 72'h1);
      sendByte(8'hD2, 0);
      checkOutput("ack_rcvd_before_eop", 72'(pkt_rcvd), 72'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("ack_rcvd",   72'(pkt_rcvd), 72'h1);
      checkOutput("ack_type",   72'(pkt_type), 72'h2);
      checkOutput("ack_hshake", 72'(hshake),   72'hD2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ack_release_rcvd", 72'(pkt_rcvd), 72'h0);
      checkOutput("ack_release_type", 72'(pkt_type), 72'h0);

      $display("[TB] IN token");
      sendSync(0);
      sendByte(8'b0110_1001, 0);
      sendBits({69'h0, 7'h05, 4'h1}, 11, 0);
      checkOutput("tok_crc_en", 72'(crc_en), 72'h1);
      sendBits(80'b10011, 5, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("tok_token",  72'(token),    72'(19'b01101001_0000101_0001));
      checkOutput("tok_type",   72'(pkt_type), 72'h1);
      checkOutput("tok_hshake_held", 72'(hshake), 72'hD2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] DATA0 with bad CRC");
      sendSync(0);
      sendByte(8'hC3, 0);
      sendBits({64'hDEADBEEF_01234567, 16'hA5A5}, 80, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("crcbad_err",  72'(pkt_err),  72'h1);
      checkOutput("crcbad_rcvd", 72'(pkt_rcvd), 72'h0);
      checkOutput("crcbad_data", data,          72'h0);
      idleCycle();
      checkOutput("crcbad_err_pulse", 72'(pkt_err), 72'h0);

      $display("[TB] bad PID then good ACK");
      sendSync(0);
      sendByte(8'hD3, 0);
      checkOutput("badpid_err", 72'(pkt_err), 72'h1);
      idleCycle();
      sendSync(0);
      sendByte(8'hD2, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("badpid_next_rcvd", 72'(pkt_rcvd), 72'h1);
      checkOutput("badpid_next_type", 72'(pkt_type), 72'h2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] overlong and short packets");
      sendSync(0);
      sendByte(8'hD2, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("long_err", 72'(pkt_err), 72'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("long_eop_ignored", 72'(pkt_rcvd), 72'h0);
      sendSync(0);
      sendByte(8'b0110_1001, 0);
      sendBits(80'b10110, 5, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("short_err",  72'(pkt_err),  72'h1);
      checkOutput("short_rcvd", 72'(pkt_rcvd), 72'h0);

      $display("[TB] OUT token with valid gaps, last bit with eop");
      sendSync(1);
      sendByte(8'hE1, 1);
      sendBits({65'h0, 7'h3A, 4'hC, 4'b0110}, 15, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("gap_rcvd",  72'(pkt_rcvd), 72'h1);
      checkOutput("gap_type",  72'(pkt_type), 72'h1);
      checkOutput("gap_token", 72'(token),    72'({8'hE1, 7'h3A, 4'hC}));

      $display("[TB] packet during DONE is dropped");
      sendSync(0);
      sendByte(8'h5A, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("done_rcvd",   72'(pkt_rcvd), 72'h1);
      checkOutput("done_type",   72'(pkt_type), 72'h1);
      checkOutput("done_hshake", 72'(hshake),   72'hD2);
      checkOutput("done_err",    72'(pkt_err),  72'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("done_ack_type", 72'(pkt_type), 72'h0);
      sendSync(0);
      sendByte(8'h5A, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("nak_hshake", 72'(hshake),   72'h5A);
      checkOutput("nak_type",   72'(pkt_type), 72'h2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] reset in the middle of a data packet");
      sendSync(0);
      sendByte(8'hC3, 0);
      sendBits(80'hFFFFF, 20, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_crc_en", 72'(crc_en),   72'h0);
      checkOutput("midrst_err",    72'(pkt_err),  72'h0);
      checkOutput("midrst_hshake", 72'(hshake),   72'h0);
      checkOutput("midrst_token",  72'(token),    72'h0);
      checkOutput("midrst_rcvd",   72'(pkt_rcvd), 72'h0);
      s_valid = 1'b0;
      s_in    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle();
      checkOutput("midrst_no_err", 72'(pkt_err), 72'h0);

      $display("[TB] DATA1 with good CRC after reset");
      sendSync(0);
      sendByte(8'h4B, 0);
      sendBits({64'h01234567_89ABCDEF, 16'h1234}, 80, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("data_rcvd",  72'(pkt_rcvd), 72'h1);
      checkOutput("data_type",  72'(pkt_type), 72'h3);
      checkOutput("data_value", data,          {8'h4B, 64'h01234567_89ABCDEF});
      checkOutput("data_token_held", 72'(token), 72'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("data_release_rcvd", 72'(pkt_rcvd), 72'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bs_decoder.md
BS_DECODER -- requirements
Module: bs_decoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are clk and rst_n.
REQ-002 Ports SHALL be as follows (clock and reset first):
  clk  in  1  system clock
  rst_n  in  1  async active-low reset
  s_in  in  1  serial bit, already NRZI-decoded and unstuffed, MSB-first
  s_valid  in  1  s_in carries a bit this cycle
  eop  in  1  end-of-packet seen on line, one-cycle pulse
  crc_ok  in  1  CRC checker residue good, sampled with eop
  pkt_ack  in  1  ProtocolFSM has consumed the packet
  pkt_type  out  2  00 none, 01 token, 10 handshake, 11 data
  data  out  72  PID + 64 payload bits
  token  out  19  PID + addr7 + endp4
  hshake  out  8  PID
  pkt_rcvd  out  1  packet valid, level, held until pkt_ack
  pkt_err  out  1  one-cycle error pulse
  crc_en  out  1  bit is fed to CRC checker
  crc_clr  out  1  clear CRC checker, one-cycle pulse

Function
REQ-003 PID byte bit layout SHALL be [7:4] = ~PID, [3:0] = PID; category SHALL be PID[1:0] (01 token, 10 handshake, 11 data; 00 is invalid).
REQ-004 Bits after the PID SHALL be 0 for handshake, 16 for token (11 field + 5 CRC) and 80 for data (64 field + 16 CRC).
REQ-005 States SHALL be IDLE, PID, PAYLOAD, WAIT_EOP and DONE; bits are consumed only in cycles where s_valid=1.
REQ-006 IDLE: an 8-bit window SHALL shift in s_in; window == 8'b0000_0001 -> PID, crc_clr=1, 7-bit counter cleared.
REQ-007 PID: the module SHALL shift in 8 bits; on the 8th bit, check mismatch or category 00 -> pkt_err=1 and IDLE; handshake -> WAIT_EOP; token or data -> PAYLOAD.
REQ-008 PAYLOAD: crc_en SHALL equal s_valid; only the field bits (not CRC bits) shift into the capture SIPO; when the expected count is reached -> WAIT_EOP.
REQ-009 WAIT_EOP: eop with crc_ok=1 (or handshake, where crc_ok is ignored) SHALL register the outputs, set pkt_rcvd=1 and pkt_type, and enter DONE; eop with crc_ok=0 -> pkt_err and IDLE.
REQ-010 Any valid bit in WAIT_EOP (overlong packet) SHALL cause pkt_err and return to IDLE.
REQ-011 eop in PID or PAYLOAD (short packet) SHALL cause pkt_err and return to IDLE; eop in IDLE SHALL be ignored.
REQ-012 If the final expected bit and eop arrive in the same cycle, the bit SHALL be counted first, then eop evaluated as in WAIT_EOP.
REQ-013 Latency: pkt_rcvd SHALL assert on the clock edge after the cycle in which eop is sampled.
REQ-014 DONE: pkt_rcvd, pkt_type and the field outputs SHALL be held stable; pkt_ack=1 -> IDLE, and pkt_rcvd=0 and pkt_type=00 on the next cycle.
REQ-015 In DONE, line bits and eop SHALL be ignored (packet dropped silently).
REQ-016 Only the field matching pkt_type SHALL be updated; the other fields SHALL hold their previous values.
REQ-017 The counter SHALL be 7 bits wide; its maximum count of 88 SHALL never wrap.

Reset
REQ-018 On rst_n low, the module SHALL asynchronously enter IDLE, with the sync window, counter and SIPO cleared.
REQ-019 During reset, all outputs SHALL be 0.
REQ-020 Reset mid-packet SHALL discard the packet with no pkt_err.

Structure
REQ-021 Shared package usb_pkg SHALL hold SYNC 8'b0000_0001, the type codes 01/10/11, the payload sizes 0/16/80, the field widths 72/19/8 and the state enum.
REQ-022 The module SHALL use the sub-module sipo_register (parameterized width, shift-left, load-enable), instanced once at 72 bits, plus the existing counter #(7).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  SYNC, ACK PID 8'b1101_0010, eop -> pkt_rcvd=1, pkt_type=10, hshake=8'hD2, 1 cycle after eop.
  SYNC, IN token 8'b0110_1001, addr 7'h05, endp 4'h1, 5 CRC bits, eop with crc_ok=1 -> token=19'b01101001_0000101_0001, pkt_type=01.
  SYNC, DATA0 PID 8'hC3, 64'hDEADBEEF_01234567, 16 CRC bits, crc_ok=0 at eop -> pkt_err pulse, pkt_rcvd stays 0.
  SYNC, PID 8'hD3 (bad check) -> pkt_err after 8th PID bit, then IDLE; a following good ACK is decoded.
  s_valid gaps on alternate cycles during a token, last bit coincident with eop -> packet accepted.
  Second packet sent while in DONE -> ignored; pkt_ack -> IDLE, next packet decoded; rst_n pulsed mid-data -> all outputs 0, no pkt_err.
